// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type, default frame constants and a
// constant-evaluable clog2 helper used to size counters.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
package uart_pkg;

  localparam int UART_OVERSAMPLING = 16;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } uart_rx_state_t;

  // Smallest width able to hold values 0 .. value-1 (returns 0 for value <= 1).
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver output bus: byte holding register with valid/ready handshake plus
// the per-frame error pulses. The receiver drives it through the master
// modport, the consumer through the slave modport.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 framing_error;
  logic                 overrun;
  logic                 parity_error;

  modport master (
    output data,
    output valid,
    input  ready,
    output framing_error,
    output overrun,
    output parity_error
  );

  modport slave (
    input  data,
    input  valid,
    output ready,
    input  framing_error,
    input  overrun,
    input  parity_error
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input. The reset value
// is a parameter so an idle-high line does not look like a start edge while
// reset is being released.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; only q is safe to use downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: deserialises start + DATA_BITS (+ optional parity) + stop
// frames from an oversampled tick and presents each byte on a valid/ready
// holding register. Framing errors, overruns and parity errors are reported
// as one-cycle registered pulses.
// Optional feature macro: UART_RX_PARITY_EN (parity bit after the data bits;
// without it parity_error is tied low).
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLING = UART_OVERSAMPLING,
  parameter int DATA_BITS    = UART_DATA_BITS,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      tick,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int TW = clog2(OVERSAMPLING);
  localparam int BW = clog2(DATA_BITS + 1);

  // Tick counts at which a sample is taken: mid start bit, then whole bits.
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLING / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLING - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic                 rxs;
  uart_rx_state_t       state;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] data_reg;
  logic                 valid_reg;
  logic                 framing_reg;
  logic                 overrun_reg;
  logic                 accept;
  logic                 tick_at_half;
  logic                 tick_at_full;

  uart_rx_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rxs)
  );

  assign accept       = valid_reg && bus.ready;
  assign tick_at_half = tick && (tcnt == T_HALF);
  assign tick_at_full = tick && (tcnt == T_FULL);

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic parity_reg;
`else
  logic unused_cfg;
  assign unused_cfg = PARITY_ODD;
`endif

  // Frame FSM with counters, shift register, holding register and pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tcnt        <= '0;
      bcnt        <= '0;
      shreg       <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      framing_reg <= 1'b0;
      overrun_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit     <= 1'b0;
      parity_reg  <= 1'b0;
`endif
    end else begin
      framing_reg <= 1'b0;
      overrun_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
      // Consumer handshake; a load in the STOP branch below overrides this.
      if (accept) begin
        valid_reg <= 1'b0;
      end

      case (state)
        IDLE: begin
          // Start detection runs every clk, independent of tick.
          if (!rxs) begin
            tcnt  <= '0;
            state <= START;
          end
        end

        START: begin
          if (tick_at_half) begin
            if (!rxs) begin
              tcnt  <= '0;
              bcnt  <= '0;
              state <= DATA;
            end else begin
              // Line went back high before mid-start: treat as a glitch.
              state <= IDLE;
            end
          end else if (tick) begin
            tcnt <= tcnt + 1'b1;
          end
        end

        DATA: begin
          if (tick_at_full) begin
            tcnt  <= '0;
            // LSB arrives first, so shift right and insert at the MSB.
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
            if (bcnt == B_LAST) begin
              bcnt  <= '0;
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end else if (tick) begin
            tcnt <= tcnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_at_full) begin
            tcnt    <= '0;
            par_bit <= rxs;
            state   <= STOP;
          end else if (tick) begin
            tcnt <= tcnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (tick_at_full) begin
            tcnt <= '0;
            if (rxs) begin
              // Load when the register is free or being emptied this cycle.
              if (!valid_reg || bus.ready) begin
                data_reg  <= shreg;
                valid_reg <= 1'b1;
              end else begin
                overrun_reg <= 1'b1;
              end
              state <= IDLE;
            end else begin
              framing_reg <= 1'b1;
              state       <= WAIT_IDLE;
            end
`ifdef UART_RX_PARITY_EN
            // Expected parity bit is the data XOR, inverted for odd parity.
            parity_reg <= par_bit ^ (^shreg) ^ PARITY_ODD;
`endif
          end else if (tick) begin
            tcnt <= tcnt + 1'b1;
          end
        end

        WAIT_IDLE: begin
          // Hold off until the line is released after a bad stop bit.
          if (rxs) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.data          = data_reg;
  assign bus.valid         = valid_reg;
  assign bus.framing_error = framing_reg;
  assign bus.overrun       = overrun_reg;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_error  = parity_reg;
`else
  assign bus.parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: 25 MHz clock, 115200 x 16 tick from a fractional
// accumulator, bit-level line driver, and a scoreboard of expected bytes.
module tb_uart_rx;

  localparam int BIT_CYC    = 217;
  localparam bit PARITY_ODD = 1'b0;

  logic clk;
  logic reset;
  logic tick;
  logic rx;
  logic ready;
  logic unused_par;

  int checks;
  int errors;
  int acc_cnt;
  int vcyc_cnt;
  int fe_cnt;
  int ovr_cnt;
  int pe_cnt;
  int tick_acc;

  logic [7:0] exp_q[$];

  uart_rx_if #(.DATA_BITS(8)) bus ();

  assign bus.ready = ready;

  uart_rx #(
    .OVERSAMPLING (16),
    .DATA_BITS    (8),
    .PARITY_ODD   (PARITY_ODD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .rx    (rx),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  // Baud tick: 1.8432 MHz derived from 25 MHz by fractional accumulation.
  initial begin
    tick     = 1'b0;
    tick_acc = 0;
    forever begin
      @(posedge clk);
      #5;
      tick_acc = tick_acc + 18432;
      if (tick_acc >= 250000) begin
        tick_acc = tick_acc - 250000;
        tick = 1'b1;
      end else begin
        tick = 1'b0;
      end
    end
  end

  // Scoreboard / event monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.valid) vcyc_cnt++;
      if (bus.framing_error) fe_cnt++;
      if (bus.overrun) ovr_cnt++;
      if (bus.parity_error) pe_cnt++;
      if (bus.valid && bus.ready) begin
        acc_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rx_byte got %h expected none", bus.data);
        end else begin
          logic [7:0] exp_b;
          exp_b = exp_q.pop_front();
          if (bus.data !== exp_b) begin
            errors++;
            $display("FAIL rx_byte got %h expected %h", bus.data, exp_b);
          end
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #5;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    rx = 1'b0;
    wait_cyc(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(BIT_CYC);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ PARITY_ODD ^ par_flip;
    wait_cyc(BIT_CYC);
`else
    unused_par = par_flip;
`endif
    rx = stop_bit;
    wait_cyc(BIT_CYC);
    rx = 1'b1;
    wait_cyc(BIT_CYC);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    wait_cyc(4);
    checks++; if (bus.data !== 8'h00) begin errors++; $display("FAIL reset_data got %h expected 00", bus.data); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", bus.valid); end
    checks++; if (bus.framing_error !== 1'b0) begin errors++; $display("FAIL reset_fe got %b expected 0", bus.framing_error); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b expected 0", bus.overrun); end
    checks++; if (bus.parity_error !== 1'b0) begin errors++; $display("FAIL reset_pe got %b expected 0", bus.parity_error); end
    reset = 1'b0;
    wait_cyc(BIT_CYC);
  endtask

  task automatic test_basic;
    logic [7:0] pats [4];
    pats = '{8'hA5, 8'h00, 8'hFF, 8'h3C};
    for (int k = 0; k < 4; k++) begin
      int a0, v0, f0, o0, p0;
      a0 = acc_cnt; v0 = vcyc_cnt; f0 = fe_cnt; o0 = ovr_cnt; p0 = pe_cnt;
      exp_q.push_back(pats[k]);
      send_frame(pats[k], 1'b1, 1'b0);
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_pending got %0d expected 0 byte %h", exp_q.size(), pats[k]); exp_q.delete(); end
      checks++; if (acc_cnt - a0 != 1) begin errors++; $display("FAIL basic_accepts got %0d expected 1", acc_cnt - a0); end
      checks++; if (vcyc_cnt - v0 != 1) begin errors++; $display("FAIL basic_valid_cycles got %0d expected 1", vcyc_cnt - v0); end
      checks++; if ((fe_cnt - f0) + (ovr_cnt - o0) + (pe_cnt - p0) != 0) begin errors++; $display("FAIL basic_errors got %0d expected 0", (fe_cnt - f0) + (ovr_cnt - o0) + (pe_cnt - p0)); end
    end
  endtask

  task automatic test_glitch;
    int a0, f0, o0;
    a0 = acc_cnt; f0 = fe_cnt; o0 = ovr_cnt;
    rx = 1'b0;
    wait_cyc(41);
    rx = 1'b1;
    wait_cyc(2 * BIT_CYC);
    checks++; if (acc_cnt - a0 != 0) begin errors++; $display("FAIL glitch_accepts got %0d expected 0", acc_cnt - a0); end
    checks++; if ((fe_cnt - f0) + (ovr_cnt - o0) != 0) begin errors++; $display("FAIL glitch_errors got %0d expected 0", (fe_cnt - f0) + (ovr_cnt - o0)); end
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, 1'b0);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL glitch_recover got %0d pending expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_framing;
    int a0, f0;
    a0 = acc_cnt; f0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    checks++; if (fe_cnt - f0 != 1) begin errors++; $display("FAIL framing_pulse got %0d expected 1", fe_cnt - f0); end
    checks++; if (acc_cnt - a0 != 0) begin errors++; $display("FAIL framing_accepts got %0d expected 0", acc_cnt - a0); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL framing_valid got %b expected 0", bus.valid); end
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL framing_next got %0d pending expected 0", exp_q.size()); exp_q.delete(); end
    checks++; if (fe_cnt - f0 != 1) begin errors++; $display("FAIL framing_next_fe got %0d expected 1", fe_cnt - f0); end
  endtask

  task automatic test_back_to_back;
    int a0, o0;
    a0 = acc_cnt; o0 = ovr_cnt;
    ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL overrun_valid got %b expected 1", bus.valid); end
    checks++; if (bus.data !== 8'h11) begin errors++; $display("FAIL overrun_data got %h expected 11", bus.data); end
    checks++; if (ovr_cnt - o0 != 1) begin errors++; $display("FAIL overrun_pulse got %0d expected 1", ovr_cnt - o0); end
    checks++; if (acc_cnt - a0 != 0) begin errors++; $display("FAIL overrun_accepts got %0d expected 0", acc_cnt - a0); end
    ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL overrun_hold got %b expected 1", bus.valid); end
    @(negedge clk);
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL overrun_drop got %b expected 0", bus.valid); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL overrun_pending got %0d expected 0", exp_q.size()); exp_q.delete(); end
    wait_cyc(2);
  endtask

  task automatic test_reset_midframe;
    int f0, o0;
    // Leave a byte pending so the reset has visible outputs to clear.
    ready = 1'b0;
    send_frame(8'h42, 1'b1, 1'b0);
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL prereset_valid got %b expected 1", bus.valid); end
    rx = 1'b0;
    wait_cyc(BIT_CYC);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      wait_cyc(BIT_CYC);
    end
    wait_cyc(BIT_CYC / 2);
    reset = 1'b1;
    #1;
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b expected 0", bus.valid); end
    checks++; if (bus.data !== 8'h00) begin errors++; $display("FAIL midreset_data got %h expected 00", bus.data); end
    wait_cyc(3);
    ready = 1'b1;
    reset = 1'b0;
    f0 = fe_cnt; o0 = ovr_cnt;
    wait_cyc(BIT_CYC * 6);
    checks++; if ((fe_cnt - f0) + (ovr_cnt - o0) != 0) begin errors++; $display("FAIL release_pulses got %0d expected 0", (fe_cnt - f0) + (ovr_cnt - o0)); end
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL postreset_pending got %0d expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_parity;
    int p0;
`ifdef UART_RX_PARITY_EN
    p0 = pe_cnt;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    checks++; if (pe_cnt - p0 != 1) begin errors++; $display("FAIL parity_bad got %0d expected 1", pe_cnt - p0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL parity_bad_data got %0d pending expected 0", exp_q.size()); exp_q.delete(); end
    p0 = pe_cnt;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    checks++; if (pe_cnt - p0 != 0) begin errors++; $display("FAIL parity_good got %0d expected 0", pe_cnt - p0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL parity_good_data got %0d pending expected 0", exp_q.size()); exp_q.delete(); end
`else
    p0 = pe_cnt;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    checks++; if (pe_cnt != 0 || p0 != 0) begin errors++; $display("FAIL parity_tied got %0d expected 0", pe_cnt); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL parity_data got %0d pending expected 0", exp_q.size()); exp_q.delete(); end
`endif
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    acc_cnt    = 0;
    vcyc_cnt   = 0;
    fe_cnt     = 0;
    ovr_cnt    = 0;
    pe_cnt     = 0;
    unused_par = 1'b0;
    reset      = 1'b1;
    rx         = 1'b1;
    ready      = 1'b1;
    @(posedge clk);
    #5;
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_midframe();
    test_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
